// File: rtl/voting_session_ctrl.sv
// -----------------------------------------------------------------------------
// voting_session_ctrl
//
// Ballot sequencer in front of the voting-machine count datapath. An officer
// arms one ballot at a time; the voter's first button activity on an armed
// ballot is consumed as either a valid vote (one button) or a spoilt ballot
// (several buttons). Abandoned ballots time out. Once voting is declared over
// the session freezes until reset.
//
// Parameters
//   N_CAND   number of candidate buttons / counters
//   CNT_W    width of the ballot total (matches the candidate counter width)
//   TIMEOUT  maximum cycles a ballot stays armed without a press (>= 2)
//
// Ports
//   clk            in   1       system clock, rising edge
//   rst            in   1       asynchronous reset, active-high
//   i_ballot_en    in   1       officer issues a ballot (level, sampled in IDLE)
//   i_candidate    in   N_CAND  candidate buttons, bit k = candidate k+1
//   i_voting_over  in   1       close the session (level)
//   o_inc          out  N_CAND  one-hot 1-cycle increment to candidate counters
//   o_spoilt       out  1       1-cycle pulse: ballot cast with >1 button
//   o_timeout      out  1       1-cycle pulse: armed ballot expired unused
//   o_ready        out  1       ballot armed lamp (high while ARMED)
//   o_closed       out  1       session closed (high while CLOSED)
//   o_total        out  CNT_W   ballots consumed (valid + spoilt), saturating
// -----------------------------------------------------------------------------
module voting_session_ctrl #(
  parameter int N_CAND  = 3,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ballot_en,
  input  logic [N_CAND-1:0] i_candidate,
  input  logic              i_voting_over,
  output logic [N_CAND-1:0] o_inc,
  output logic              o_spoilt,
  output logic              o_timeout,
  output logic              o_ready,
  output logic              o_closed,
  output logic [CNT_W-1:0]  o_total
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   TOTAL_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAST,
    RELEASE,
    CLOSED
  } state_t;

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [N_CAND-1:0]   choice, choice_n;   // press latched on leaving ARMED
  logic                spoil, spoil_n;     // ballot latched as spoilt
  logic [N_CAND-1:0]   inc_n;
  logic                spoilt_n;
  logic                timeout_n;
  logic [CNT_W-1:0]    total_n;

  logic press_any;
  logic press_one;

  assign press_any = |i_candidate;
  assign press_one = $onehot(i_candidate);

  // Next-state and next-output logic.
  // NOTE: every signal written here gets a default first so no path can leave
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    choice_n  = choice;
    spoil_n   = spoil;
    inc_n     = '0;
    spoilt_n  = 1'b0;
    timeout_n = 1'b0;
    total_n   = o_total;

    unique case (state)
      IDLE: begin
        if (i_voting_over) begin
          state_n = CLOSED;
        end else if (i_ballot_en && !press_any && (o_total != TOTAL_MAX)) begin
          // Buttons already held would cast instantly, so arming waits for
          // a clean panel; a saturated total refuses further ballots.
          state_n = ARMED;
          timer_n = '0;
        end
      end

      ARMED: begin
        if (i_voting_over) begin
          state_n = CLOSED;               // ballot discarded, nothing counted
        end else if (press_one) begin
          state_n  = CAST;
          choice_n = i_candidate;
          spoil_n  = 1'b0;
        end else if (press_any) begin
          state_n  = CAST;
          choice_n = '0;
          spoil_n  = 1'b1;
        end else if (timer == TIMER_LAST) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
          timer_n   = '0;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end

      CAST: begin
        // The pulse always completes, even if the session closes now.
        if (spoil) spoilt_n = 1'b1;
        else       inc_n    = choice;
        total_n = (o_total == TOTAL_MAX) ? o_total : o_total + CNT_W'(1);
        state_n = i_voting_over ? CLOSED : RELEASE;
      end

      RELEASE: begin
        // Wait for all buttons up so a held button counts only once.
        if (i_voting_over)  state_n = CLOSED;
        else if (!press_any) state_n = IDLE;
      end

      CLOSED: state_n = CLOSED;

      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs. Status lamps are registered from the next
  // state so they line up exactly with the state register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      choice    <= '0;
      spoil     <= 1'b0;
      o_inc     <= '0;
      o_spoilt  <= 1'b0;
      o_timeout <= 1'b0;
      o_ready   <= 1'b0;
      o_closed  <= 1'b0;
      o_total   <= '0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      choice    <= choice_n;
      spoil     <= spoil_n;
      o_inc     <= inc_n;
      o_spoilt  <= spoilt_n;
      o_timeout <= timeout_n;
      o_ready   <= (state_n == ARMED);
      o_closed  <= (state_n == CLOSED);
      o_total   <= total_n;
    end
  end

endmodule

// File: tb/tb_voting_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_voting_session_ctrl
//
// Self-checking bench for voting_session_ctrl. The main instance uses the
// default parameters; a second instance with CNT_W=2 exercises saturation of
// the ballot total. Expected pulse events of the main instance are queued when
// the stimulus is driven and popped by a monitor when a pulse appears.
// -----------------------------------------------------------------------------
module tb_voting_session_ctrl;

  localparam int N_CAND = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              ballot_en;
  logic [N_CAND-1:0] candidate;
  logic              voting_over;
  logic [N_CAND-1:0] inc;
  logic              spoilt;
  logic              timeout;
  logic              ready;
  logic              closed;
  logic [5:0]        total;

  logic              s_ballot_en;
  logic [N_CAND-1:0] s_candidate;
  logic              s_voting_over;
  logic [N_CAND-1:0] s_inc;
  logic              s_spoilt;
  logic              s_timeout;
  logic              s_ready;
  logic              s_closed;
  logic [1:0]        s_total;

  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct packed {
    logic [N_CAND-1:0] inc;
    logic              spoilt;
    logic              timeout;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  voting_session_ctrl #(.N_CAND(N_CAND), .CNT_W(6), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_ballot_en   (ballot_en),
    .i_candidate   (candidate),
    .i_voting_over (voting_over),
    .o_inc         (inc),
    .o_spoilt      (spoilt),
    .o_timeout     (timeout),
    .o_ready       (ready),
    .o_closed      (closed),
    .o_total       (total)
  );

  voting_session_ctrl #(.N_CAND(N_CAND), .CNT_W(2), .TIMEOUT(4)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .i_ballot_en   (s_ballot_en),
    .i_candidate   (s_candidate),
    .i_voting_over (s_voting_over),
    .o_inc         (s_inc),
    .o_spoilt      (s_spoilt),
    .o_timeout     (s_timeout),
    .o_ready       (s_ready),
    .o_closed      (s_closed),
    .o_total       (s_total)
  );

  // Pulse monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && ((inc != '0) || spoilt || timeout)) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        bad_cnt++;
        $display("FAIL unexpected_pulse: got inc=%b spoilt=%b timeout=%b, want no pulse",
                 inc, spoilt, timeout);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if ({inc, spoilt, timeout} !== e) begin
          bad_cnt++;
          $display("FAIL pulse_event: got inc=%b spoilt=%b timeout=%b, want inc=%b spoilt=%b timeout=%b",
                   inc, spoilt, timeout, e.inc, e.spoilt, e.timeout);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [N_CAND-1:0] i, input logic s, input logic t);
    ev_t e;
    e.inc = i; e.spoilt = s; e.timeout = t;
    exp_q.push_back(e);
  endtask

  task automatic arm(input string tag);
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    total_cnt++;
    if (ready !== 1'b1) begin
      bad_cnt++; $display("FAIL %s_arm_ready: got %b want 1", tag, ready);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ballot_en = 0; candidate = '0; voting_over = 0;
    s_ballot_en = 0; s_candidate = '0; s_voting_over = 0;
    #20;
    total_cnt++;
    if ({inc, spoilt, timeout, ready, closed, total} !== '0) begin
      bad_cnt++;
      $display("FAIL reset_outputs: got inc=%b sp=%b to=%b rdy=%b cl=%b tot=%0d want all 0",
               inc, spoilt, timeout, ready, closed, total);
    end
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({ready, closed, total} !== '0) begin
      bad_cnt++; $display("FAIL reset_idle: got rdy=%b cl=%b tot=%0d want 0", ready, closed, total);
    end
  endtask

  task automatic test_single_vote();
    arm("single");
    candidate = 3'b001;
    push_exp(3'b001, 1'b0, 1'b0);
    tick();
    total_cnt++;
    if ({ready, inc} !== 4'b0000) begin
      bad_cnt++; $display("FAIL single_cast_cycle: got rdy=%b inc=%b want 0 000", ready, inc);
    end
    tick();
    total_cnt++;
    if (inc !== 3'b001 || total !== 6'd1) begin
      bad_cnt++; $display("FAIL single_pulse: got inc=%b tot=%0d want 001 1", inc, total);
    end
    candidate = '0;
    tick();
    total_cnt++;
    if (inc !== 3'b000) begin
      bad_cnt++; $display("FAIL single_pulse_width: got inc=%b want 000", inc);
    end
  endtask

  task automatic test_held_button();
    int pulses = 0;
    arm("held");
    candidate = 3'b010;
    push_exp(3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inc != '0) pulses++;
    end
    total_cnt++;
    if (pulses !== 1) begin
      bad_cnt++; $display("FAIL held_pulse_count: got %0d want 1", pulses);
    end
    ballot_en = 1'b1;
    tick();
    total_cnt++;
    if (ready !== 1'b0) begin
      bad_cnt++; $display("FAIL held_enable_in_release: got rdy=%b want 0", ready);
    end
    ballot_en = 1'b0; candidate = '0;
    tick();
    candidate = 3'b001;
    tick();
    ballot_en = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (ready !== 1'b0 || total !== 6'd2) begin
      bad_cnt++; $display("FAIL held_idle_refuse: got rdy=%b tot=%0d want 0 2", ready, total);
    end
    ballot_en = 1'b0; candidate = '0;
    tick();
  endtask

  task automatic test_spoilt();
    arm("spoilt");
    candidate = 3'b011;
    push_exp(3'b000, 1'b1, 1'b0);
    tick();
    tick();
    total_cnt++;
    if (spoilt !== 1'b1 || inc !== 3'b000 || total !== 6'd3) begin
      bad_cnt++; $display("FAIL spoilt_pulse: got sp=%b inc=%b tot=%0d want 1 000 3", spoilt, inc, total);
    end
    candidate = '0;
    tick();
    total_cnt++;
    if (spoilt !== 1'b0) begin
      bad_cnt++; $display("FAIL spoilt_width: got %b want 0", spoilt);
    end
  endtask

  task automatic test_timeout();
    int ready_cycles = 0;
    arm("timeout");
    push_exp(3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (!ready) break;
      ready_cycles++;
      tick();
    end
    total_cnt++;
    if (ready_cycles !== 16 || timeout !== 1'b1) begin
      bad_cnt++; $display("FAIL timeout_len: got ready_cycles=%0d to=%b want 16 1", ready_cycles, timeout);
    end
    tick();
    total_cnt++;
    if (timeout !== 1'b0 || total !== 6'd3) begin
      bad_cnt++; $display("FAIL timeout_after: got to=%b tot=%0d want 0 3", timeout, total);
    end
    // A press in the very last armed cycle still wins over the timeout.
    arm("last_cycle");
    repeat (15) tick();
    total_cnt++;
    if (ready !== 1'b1) begin
      bad_cnt++; $display("FAIL last_cycle_ready: got %b want 1", ready);
    end
    candidate = 3'b100;
    push_exp(3'b100, 1'b0, 1'b0);
    tick();
    total_cnt++;
    if (timeout !== 1'b0 || ready !== 1'b0) begin
      bad_cnt++; $display("FAIL last_cycle_no_timeout: got to=%b rdy=%b want 0 0", timeout, ready);
    end
    tick();
    total_cnt++;
    if (inc !== 3'b100 || total !== 6'd4) begin
      bad_cnt++; $display("FAIL last_cycle_vote: got inc=%b tot=%0d want 100 4", inc, total);
    end
    candidate = '0;
    tick();
  endtask

  task automatic test_close_armed();
    arm("close");
    voting_over = 1'b1;
    tick();
    total_cnt++;
    if (closed !== 1'b1 || ready !== 1'b0) begin
      bad_cnt++; $display("FAIL close_armed: got cl=%b rdy=%b want 1 0", closed, ready);
    end
    voting_over = 1'b0; candidate = 3'b001; ballot_en = 1'b1;
    repeat (5) tick();
    total_cnt++;
    if (closed !== 1'b1 || ready !== 1'b0 || inc !== 3'b000 || total !== 6'd4) begin
      bad_cnt++; $display("FAIL close_frozen: got cl=%b rdy=%b inc=%b tot=%0d want 1 0 000 4",
                          closed, ready, inc, total);
    end
    candidate = '0; ballot_en = 1'b0;
  endtask

  task automatic test_reset_mid_cast();
    apply_reset();
    arm("rst_cast");
    candidate = 3'b001;
    tick();
    tick();
    total_cnt++;
    if (inc !== 3'b001 || total !== 6'd1) begin
      bad_cnt++; $display("FAIL rst_cast_pre: got inc=%b tot=%0d want 001 1", inc, total);
    end
    // Reset lands before the monitor samples, so no event is queued.
    rst = 1'b1;
    #1;
    total_cnt++;
    if (inc !== 3'b000 || total !== 6'd0 || ready !== 1'b0 || closed !== 1'b0) begin
      bad_cnt++; $display("FAIL rst_cast_async: got inc=%b tot=%0d rdy=%b cl=%b want 000 0 0 0",
                          inc, total, ready, closed);
    end
    candidate = '0;
    tick();
    rst = 1'b0;
    tick();
    arm("rst_rearm");
    candidate = 3'b010;
    push_exp(3'b010, 1'b0, 1'b0);
    tick();
    tick();
    total_cnt++;
    if (inc !== 3'b010 || total !== 6'd1) begin
      bad_cnt++; $display("FAIL rst_rearm_vote: got inc=%b tot=%0d want 010 1", inc, total);
    end
    candidate = '0;
    tick();
  endtask

  task automatic test_over_in_cast();
    arm("over_cast");
    candidate = 3'b100;
    push_exp(3'b100, 1'b0, 1'b0);
    tick();
    voting_over = 1'b1; candidate = '0;
    tick();
    total_cnt++;
    if (inc !== 3'b100 || closed !== 1'b1 || total !== 6'd2) begin
      bad_cnt++; $display("FAIL over_cast_pulse: got inc=%b cl=%b tot=%0d want 100 1 2", inc, closed, total);
    end
    voting_over = 1'b0;
    tick();
    total_cnt++;
    if (inc !== 3'b000 || closed !== 1'b1) begin
      bad_cnt++; $display("FAIL over_cast_after: got inc=%b cl=%b want 000 1", inc, closed);
    end
  endtask

  task automatic test_saturate();
    for (int v = 1; v <= 3; v++) begin
      s_ballot_en = 1'b1;
      tick();
      s_ballot_en = 1'b0;
      s_candidate = 3'b001;
      tick();
      tick();
      total_cnt++;
      if (s_inc !== 3'b001 || s_total !== 2'(v)) begin
        bad_cnt++; $display("FAIL sat_vote%0d: got inc=%b tot=%0d want 001 %0d", v, s_inc, s_total, v);
      end
      s_candidate = '0;
      tick();
    end
    s_ballot_en = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (s_ready !== 1'b0 || s_total !== 2'd3) begin
      bad_cnt++; $display("FAIL sat_refuse: got rdy=%b tot=%0d want 0 3", s_ready, s_total);
    end
    s_ballot_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_held_button();
    test_spoilt();
    test_timeout();
    test_close_armed();
    test_reset_mid_cast();
    test_over_in_cast();
    test_saturate();
    tick();
    total_cnt++;
    if (exp_q.size() != 0) begin
      bad_cnt++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
